// File: rtl/prbs_pkg.sv
// prbs_pkg: shared types and elaboration helpers for the PRBS checker.
//   prbs_taps(order)     -> {N[4:0], T[4:0]} feedback taps for a PRBS order
//   is_legal_poly(order) -> 1 when the order is one of the supported polynomials
//   prbs_state_t         -> widest LFSR state vector, indexed [31:1]
//   state_e              -> checker lock FSM states
package prbs_pkg;

    typedef logic [31:1] prbs_state_t;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCK   = 1'b1
    } state_e;

    // Unsupported orders fall back to PRBS23 so elaboration reaches the
    // explicit legality check in the checker instead of failing obscurely.
    function automatic logic [9:0] prbs_taps(input int order);
        case (order)
            7:       return {5'd7,  5'd6};
            9:       return {5'd9,  5'd5};
            15:      return {5'd15, 5'd14};
            23:      return {5'd23, 5'd18};
            31:      return {5'd31, 5'd28};
            default: return {5'd23, 5'd18};
        endcase
    endfunction

    function automatic logic is_legal_poly(input int order);
        return (order == 7) || (order == 9) || (order == 15) ||
               (order == 23) || (order == 31);
    endfunction

endpackage

// File: rtl/prbs_sat_acc.sv
// prbs_sat_acc: saturating accumulator used for the error and bit counters.
//   iclk, irst_n : clock, asynchronous active-low reset
//   iclkena      : clock enable, all state holds when low
//   iclr         : synchronous clear; combined with iadd_en it loads iadd
//   iadd_en      : add iadd to the running count this cycle
//   iadd         : value to accumulate
//   ocnt         : count, sticks at all-ones instead of wrapping
module prbs_sat_acc #(
    parameter int pCNT_W = 32,
    parameter int pADD_W = 4
) (
    input  logic              iclk,
    input  logic              irst_n,
    input  logic              iclkena,
    input  logic              iclr,
    input  logic              iadd_en,
    input  logic [pADD_W-1:0] iadd,
    output logic [pCNT_W-1:0] ocnt
);

    // Sum width covers whichever operand is wider; any bit above pCNT_W
    // means the result no longer fits and the counter saturates.
    localparam int cSUM_W = ((pCNT_W > pADD_W) ? pCNT_W : pADD_W) + 1;

    logic [pCNT_W-1:0] r_cnt;
    logic [pCNT_W-1:0] w_base;
    logic [pCNT_W-1:0] w_nxt;
    logic [cSUM_W-1:0] w_sum;

    always_comb begin
        w_base = iclr ? '0 : r_cnt;
        w_sum  = cSUM_W'(w_base) + cSUM_W'(iadd);
        w_nxt  = w_base;
        if (iadd_en) begin
            if (|w_sum[cSUM_W-1:pCNT_W]) begin
                w_nxt = '1;
            end else begin
                w_nxt = w_sum[pCNT_W-1:0];
            end
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_cnt <= '0;
        end else if (iclkena) begin
            r_cnt <= w_nxt;
        end
    end

    assign ocnt = r_cnt;

endmodule

// File: rtl/prbs_chk.sv
// prbs_chk: self-synchronising PRBS checker for the inverted PRBS streams
// emitted by the link-test generators.
//   iclk, irst_n : clock, asynchronous active-low reset
//   iclkena      : clock enable, all registers hold when low
//   iclr         : synchronous clear of oerr_cnt/obit_cnt
//   ival, idat   : received word and its valid strobe
//   oval, oerr   : registered valid and per-bit error flags (idat ordering)
//   olock        : 1 while locked
//   oerr_cnt     : saturating count of flagged error bits while locked
//   obit_cnt     : saturating count of bits checked while locked
module prbs_chk
    import prbs_pkg::*;
#(
    parameter int pDAT_W     = 8,
    parameter int pMSB_FIRST = 0,
    parameter int pPOLY      = 23,
    parameter int pLOCK_N    = 16,
    parameter int pLOSS_N    = 4,
    parameter int pCNT_W     = 32
) (
    input  logic              iclk,
    input  logic              irst_n,
    input  logic              iclkena,
    input  logic              iclr,
    input  logic              ival,
    input  logic [pDAT_W-1:0] idat,
    output logic              oval,
    output logic [pDAT_W-1:0] oerr,
    output logic              olock,
    output logic [pCNT_W-1:0] oerr_cnt,
    output logic [pCNT_W-1:0] obit_cnt
);

    if (!is_legal_poly(pPOLY)) begin : g_bad_poly
        $fatal(1, "prbs_chk: pPOLY must be one of 7, 9, 15, 23, 31");
    end
    if ((pDAT_W < 1) || (pDAT_W > 64)) begin : g_bad_width
        $fatal(1, "prbs_chk: pDAT_W must be within 1..64");
    end
    if ((pLOCK_N < 1) || (pLOSS_N < 1)) begin : g_bad_thresh
        $fatal(1, "prbs_chk: pLOCK_N and pLOSS_N must be at least 1");
    end

    localparam logic [9:0]  cTAPS   = prbs_taps(pPOLY);
    localparam int          cN      = int'(cTAPS[9:5]);
    localparam int          cT      = int'(cTAPS[4:0]);
    localparam int unsigned cW      = pDAT_W;
    localparam int          cPC_W   = $clog2(pDAT_W + 1);
    localparam int          cGOOD_W = $clog2(pLOCK_N + 1);
    localparam int          cBAD_W  = $clog2(pLOSS_N + 1);
    localparam logic [cPC_W-1:0] cBITS = cPC_W'(pDAT_W);

    // Bits are processed LSB first here; MSB-first words are mirrored
    // before and after so one unrolled routine serves both orderings.
    // Returns {next_state, err}.
    function automatic logic [cN+pDAT_W-1:0] check_word(
        input logic [cN:1]       st_i,
        input logic [pDAT_W-1:0] dat
    );
        logic [cN:1]       st;
        logic [pDAT_W-1:0] err;
        logic              b;
        st  = st_i;
        err = '0;
        for (int unsigned i = 0; i < cW; i++) begin
            b      = dat[i];
            err[i] = b ^ st[cN] ^ st[cT] ^ 1'b1;
            st     = {st[cN-1:1], b};
        end
        return {st, err};
    endfunction

    logic [cN:1]         r_lfsr;
    logic                r_val;
    logic [pDAT_W-1:0]   r_err;
    state_e              r_state;
    logic [cGOOD_W-1:0]  r_good;
    logic [cBAD_W-1:0]   r_bad;

    logic [pDAT_W-1:0]    w_dat_ord;
    logic [pDAT_W-1:0]    w_err_ord;
    logic [cN+pDAT_W-1:0] w_chk;
    logic [cN:1]          w_lfsr_nxt;
    logic [pDAT_W-1:0]    w_err;
    logic                 w_err_any;
    logic [cPC_W-1:0]     w_pc;
    state_e               w_state_nxt;
    logic [cGOOD_W-1:0]   w_good_nxt;
    logic [cBAD_W-1:0]    w_bad_nxt;
    logic                 w_add_en;

    always_comb begin
        w_dat_ord = idat;
        if (pMSB_FIRST != 0) begin
            w_dat_ord = {<<{idat}};
        end
        w_chk      = check_word(r_lfsr, w_dat_ord);
        w_lfsr_nxt = w_chk[cN+pDAT_W-1:pDAT_W];
        w_err_ord  = w_chk[pDAT_W-1:0];
        w_err      = w_err_ord;
        if (pMSB_FIRST != 0) begin
            w_err = {<<{w_err_ord}};
        end
        w_err_any = |w_err;
        w_pc      = cPC_W'($countones(w_err));
    end

    // Lock FSM: next state, run counters and counter enable.
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_bad_nxt   = r_bad;
        w_add_en    = 1'b0;
        if (iclkena && ival) begin
            case (r_state)
                SEARCH: begin
                    if (w_err_any) begin
                        w_good_nxt = '0;
                    end else if (r_good == cGOOD_W'(pLOCK_N - 1)) begin
                        w_state_nxt = LOCK;
                        w_good_nxt  = '0;
                        w_bad_nxt   = '0;
                    end else begin
                        w_good_nxt = r_good + cGOOD_W'(1);
                    end
                end
                LOCK: begin
                    w_add_en = 1'b1;
                    if (!w_err_any) begin
                        w_bad_nxt = '0;
                    end else if (r_bad == cBAD_W'(pLOSS_N - 1)) begin
                        w_state_nxt = SEARCH;
                        w_good_nxt  = '0;
                        w_bad_nxt   = '0;
                    end else begin
                        w_bad_nxt = r_bad + cBAD_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = SEARCH;
                    w_good_nxt  = '0;
                    w_bad_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_state <= SEARCH;
        end else if (iclkena) begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_lfsr <= '0;
            r_val  <= 1'b0;
            r_err  <= '0;
            r_good <= '0;
            r_bad  <= '0;
        end else if (iclkena) begin
            r_val  <= ival;
            r_good <= w_good_nxt;
            r_bad  <= w_bad_nxt;
            if (ival) begin
                r_lfsr <= w_lfsr_nxt;
                r_err  <= w_err;
            end
        end
    end

    prbs_sat_acc #(
        .pCNT_W (pCNT_W),
        .pADD_W (cPC_W)
    ) u_err_acc (
        .iclk    (iclk),
        .irst_n  (irst_n),
        .iclkena (iclkena),
        .iclr    (iclr),
        .iadd_en (w_add_en),
        .iadd    (w_pc),
        .ocnt    (oerr_cnt)
    );

    prbs_sat_acc #(
        .pCNT_W (pCNT_W),
        .pADD_W (cPC_W)
    ) u_bit_acc (
        .iclk    (iclk),
        .irst_n  (irst_n),
        .iclkena (iclkena),
        .iclr    (iclr),
        .iadd_en (w_add_en),
        .iadd    (cBITS),
        .ocnt    (obit_cnt)
    );

    assign oval  = r_val;
    assign oerr  = r_err;
    assign olock = (r_state == LOCK);

endmodule

// File: tb/tb_prbs_chk.sv
// tb_prbs_chk: directed sequence with random PRBS payload, checked against a
// stream-level reference: err[n] = rx[n] ^ rx[n-N] ^ rx[n-T] ^ 1 (rx before
// reset counts as 0), lock/loss as run lengths, counters as saturating sums.
module tb_prbs_chk;

    logic clk = 1'b0;
    logic rst_n, clkena, clr;
    logic val, val_x;
    logic [7:0]  dat;
    logic [12:0] dat_c, dat_e;
    logic [0:0]  dat_d, dat_f;

    logic        oval_a, olock_a, oval_b, olock_b;
    logic [7:0]  oerr_a, oerr_b;
    logic [31:0] ecnt_a, bcnt_a;
    logic [3:0]  ecnt_b, bcnt_b;

    logic        oval_c, olock_c, oval_d, olock_d, oval_e, olock_e, oval_f, olock_f;
    logic [12:0] oerr_c, oerr_e;
    logic [0:0]  oerr_d, oerr_f;
    logic [31:0] ecnt_c, bcnt_c, ecnt_d, bcnt_d, ecnt_e, bcnt_e, ecnt_f, bcnt_f;

    always #5 clk = ~clk;

    prbs_chk #(.pDAT_W(8), .pMSB_FIRST(0), .pPOLY(23), .pLOCK_N(16), .pLOSS_N(4), .pCNT_W(32)) u_a (
        .iclk(clk), .irst_n(rst_n), .iclkena(clkena), .iclr(clr), .ival(val), .idat(dat),
        .oval(oval_a), .oerr(oerr_a), .olock(olock_a), .oerr_cnt(ecnt_a), .obit_cnt(bcnt_a));

    prbs_chk #(.pDAT_W(8), .pMSB_FIRST(0), .pPOLY(23), .pLOCK_N(16), .pLOSS_N(4), .pCNT_W(4)) u_b (
        .iclk(clk), .irst_n(rst_n), .iclkena(clkena), .iclr(clr), .ival(val), .idat(dat),
        .oval(oval_b), .oerr(oerr_b), .olock(olock_b), .oerr_cnt(ecnt_b), .obit_cnt(bcnt_b));

    prbs_chk #(.pDAT_W(13), .pMSB_FIRST(1), .pPOLY(9), .pLOCK_N(16), .pLOSS_N(4), .pCNT_W(32)) u_c (
        .iclk(clk), .irst_n(rst_n), .iclkena(clkena), .iclr(clr), .ival(val_x), .idat(dat_c),
        .oval(oval_c), .oerr(oerr_c), .olock(olock_c), .oerr_cnt(ecnt_c), .obit_cnt(bcnt_c));

    prbs_chk #(.pDAT_W(1), .pMSB_FIRST(0), .pPOLY(31), .pLOCK_N(16), .pLOSS_N(4), .pCNT_W(32)) u_d (
        .iclk(clk), .irst_n(rst_n), .iclkena(clkena), .iclr(clr), .ival(val_x), .idat(dat_d),
        .oval(oval_d), .oerr(oerr_d), .olock(olock_d), .oerr_cnt(ecnt_d), .obit_cnt(bcnt_d));

    prbs_chk #(.pDAT_W(13), .pMSB_FIRST(0), .pPOLY(15), .pLOCK_N(16), .pLOSS_N(4), .pCNT_W(32)) u_e (
        .iclk(clk), .irst_n(rst_n), .iclkena(clkena), .iclr(clr), .ival(val_x), .idat(dat_e),
        .oval(oval_e), .oerr(oerr_e), .olock(olock_e), .oerr_cnt(ecnt_e), .obit_cnt(bcnt_e));

    prbs_chk #(.pDAT_W(1), .pMSB_FIRST(1), .pPOLY(7), .pLOCK_N(16), .pLOSS_N(4), .pCNT_W(32)) u_f (
        .iclk(clk), .irst_n(rst_n), .iclkena(clkena), .iclr(clr), .ival(val_x), .idat(dat_f),
        .oval(oval_f), .oerr(oerr_f), .olock(olock_f), .oerr_cnt(ecnt_f), .obit_cnt(bcnt_f));

    int checks   = 0;
    int failures = 0;

    // Transmitted bit streams: 0 = main 8-bit stream, 1..4 = aux DUTs c..f.
    bit txs [5][4096];
    int txn [5];

    // Received history of the main stream since the last reset.
    bit rx [4096];
    int rxn;

    // Reference state for DUTs a/b (b differs only in counter width).
    bit              m_lock, m_val;
    int              m_good, m_bad;
    logic [7:0]      m_err;
    longint unsigned m_ecnt_a, m_bcnt_a, m_ecnt_b, m_bcnt_b;
    localparam longint unsigned MAX_A = 64'hFFFF_FFFF;
    localparam longint unsigned MAX_B = 15;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Next clean bit of stream s: b[n] = b[n-N] ^ b[n-T] ^ 1. The first N
    // bits are either random or chosen so a freshly reset checker sees no
    // errors from the very first bit.
    function automatic bit gen_bit(input int s, input int n_ord, input int t_ord, input bit rnd);
        int k;
        bit b;
        k = txn[s];
        if (k >= n_ord)     b = txs[s][k-n_ord] ^ txs[s][k-t_ord] ^ 1'b1;
        else if (rnd)       b = 1'($urandom);
        else if (k < t_ord) b = 1'b1;
        else                b = ~txs[s][k-t_ord];
        txs[s][k] = b;
        txn[s]    = k + 1;
        return b;
    endfunction

    function automatic bit rx_bit(input int idx);
        return (idx < 0) ? 1'b0 : rx[idx];
    endfunction

    function automatic longint unsigned sat_add(input longint unsigned base, input int add,
                                                input longint unsigned mx);
        longint unsigned s;
        s = base + longint'(add);
        return (s > mx) ? mx : s;
    endfunction

    task automatic check_ab();
        chk("a.oval",     64'(oval_a),  64'(m_val));
        chk("a.oerr",     64'(oerr_a),  64'(m_err));
        chk("a.olock",    64'(olock_a), 64'(m_lock));
        chk("a.oerr_cnt", 64'(ecnt_a),  m_ecnt_a);
        chk("a.obit_cnt", 64'(bcnt_a),  m_bcnt_a);
        chk("b.olock",    64'(olock_b), 64'(m_lock));
        chk("b.oerr_cnt", 64'(ecnt_b),  m_ecnt_b);
        chk("b.obit_cnt", 64'(bcnt_b),  m_bcnt_b);
    endtask

    // One cycle on the main stream: v=ival, ce=iclkena, cl=iclr,
    // flip=bits inverted on the clean word, zero=send all-zero word.
    task automatic step(input bit v, input bit ce, input bit cl, input logic [7:0] flip, input bit zero);
        logic [7:0] d, e;
        int         pc;
        bit         was_lock;
        d = 8'($urandom);
        e = '0;
        if (v && ce) begin
            for (int i = 0; i < 8; i++) d[i] = gen_bit(0, 23, 18, 1'b1);
            d = d ^ flip;
            if (zero) d = '0;
        end
        val = v; clkena = ce; clr = cl; dat = d;
        if (ce) begin
            if (v) begin
                for (int i = 0; i < 8; i++) begin
                    e[i]    = d[i] ^ rx_bit(rxn - 23) ^ rx_bit(rxn - 18) ^ 1'b1;
                    rx[rxn] = d[i];
                    rxn++;
                end
            end
            pc       = $countones(e);
            was_lock = m_lock;
            if (cl) begin
                m_ecnt_a = 0; m_bcnt_a = 0; m_ecnt_b = 0; m_bcnt_b = 0;
            end
            if (v && was_lock) begin
                m_ecnt_a = sat_add(m_ecnt_a, pc, MAX_A);
                m_bcnt_a = sat_add(m_bcnt_a, 8,  MAX_A);
                m_ecnt_b = sat_add(m_ecnt_b, pc, MAX_B);
                m_bcnt_b = sat_add(m_bcnt_b, 8,  MAX_B);
            end
            if (v) begin
                m_err = e;
                if (!was_lock) begin
                    if (e == 0) begin
                        m_good++;
                        if (m_good == 16) begin m_lock = 1; m_good = 0; m_bad = 0; end
                    end else m_good = 0;
                end else begin
                    if (e != 0) begin
                        m_bad++;
                        if (m_bad == 4) begin m_lock = 0; m_good = 0; m_bad = 0; end
                    end else m_bad = 0;
                end
            end
            m_val = v;
        end
        @(posedge clk);
        #1;
        check_ab();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        val = 0; val_x = 0; clr = 0; clkena = 1;
        rst_n = 0;
        #1;
        rxn = 0; m_lock = 0; m_val = 0; m_good = 0; m_bad = 0; m_err = '0;
        m_ecnt_a = 0; m_bcnt_a = 0; m_ecnt_b = 0; m_bcnt_b = 0;
        check_ab();
        chk("c.olock_rst",    64'(olock_c), 64'd0);
        chk("c.obit_cnt_rst", 64'(bcnt_c),  64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    // Aux DUTs: seeded clean streams, so lock lands exactly on word 15.
    task automatic aux_step(input int k);
        logic [12:0] wc, we;
        bit          el;
        longint unsigned nb;
        wc = '0; we = '0;
        for (int i = 0; i < 13; i++) wc[12-i] = gen_bit(1, 9, 5, 1'b0);
        for (int i = 0; i < 13; i++) we[i]    = gen_bit(3, 15, 14, 1'b0);
        dat_d[0] = gen_bit(2, 31, 28, 1'b0);
        dat_f[0] = gen_bit(4, 7, 6, 1'b0);
        dat_c = wc; dat_e = we; val_x = 1;
        @(posedge clk);
        #1;
        el = (k >= 15);
        nb = (k >= 15) ? longint'(k - 15) : 0;
        chk("c.olock", 64'(olock_c), 64'(el)); chk("c.oerr", 64'(oerr_c), 64'd0);
        chk("c.oerr_cnt", 64'(ecnt_c), 64'd0); chk("c.obit_cnt", 64'(bcnt_c), 13 * nb);
        chk("d.olock", 64'(olock_d), 64'(el)); chk("d.oerr", 64'(oerr_d), 64'd0);
        chk("d.oerr_cnt", 64'(ecnt_d), 64'd0); chk("d.obit_cnt", 64'(bcnt_d), nb);
        chk("e.olock", 64'(olock_e), 64'(el)); chk("e.oerr", 64'(oerr_e), 64'd0);
        chk("e.oerr_cnt", 64'(ecnt_e), 64'd0); chk("e.obit_cnt", 64'(bcnt_e), 13 * nb);
        chk("f.olock", 64'(olock_f), 64'(el)); chk("f.oerr", 64'(oerr_f), 64'd0);
        chk("f.oerr_cnt", 64'(ecnt_f), 64'd0); chk("f.obit_cnt", 64'(bcnt_f), nb);
        chk("c.oval", 64'(oval_c), 64'd1);
    endtask

    initial begin
        rst_n = 0; clkena = 1; clr = 0; val = 0; val_x = 0;
        dat = '0; dat_c = '0; dat_d = '0; dat_e = '0; dat_f = '0;
        for (int s = 0; s < 5; s++) txn[s] = 0;
        rxn = 0;

        do_reset();

        // Polynomial / width / bit-order sweep on the aux checkers.
        for (int k = 0; k < 40; k++) aux_step(k);
        @(negedge clk);
        val_x = 0;

        // Clean stream into a/b: lock, then 8 bits per locked word.
        repeat (40) step(1, 1, 0, 8'h00, 0);
        chk("a.locked_after_clean", 64'(olock_a), 64'd1);
        chk("a.no_err_after_clean", 64'(ecnt_a), 64'd0);

        // One channel bit error while locked -> three flagged bits.
        step(1, 1, 0, 8'h08, 0);
        repeat (5) step(1, 1, 0, 8'h00, 0);
        chk("a.single_err_total", 64'(ecnt_a), 64'd3);
        chk("a.single_err_lock", 64'(olock_a), 64'd1);

        // All-zero burst to force loss of lock, then relock.
        repeat (4) step(1, 1, 0, 8'h00, 1);
        repeat (30) step(1, 1, 0, 8'h00, 0);

        // Repeated isolated errors: b's 4-bit counters must stick at 15.
        repeat (6) begin
            step(1, 1, 0, 8'h08, 0);
            repeat (3) step(1, 1, 0, 8'h00, 0);
        end
        repeat (4) step(1, 1, 0, 8'h00, 0);
        chk("b.err_saturated", 64'(ecnt_b), 64'd15);
        chk("b.bit_saturated", 64'(bcnt_b), 64'd15);

        // Clear together with a clean counted word, then clear alone.
        step(1, 1, 1, 8'h00, 0);
        chk("b.clr_word_err", 64'(ecnt_b), 64'd0);
        chk("b.clr_word_bit", 64'(bcnt_b), 64'd8);
        step(0, 1, 1, 8'h00, 0);
        step(1, 1, 0, 8'h00, 0);

        // Clock enable low with toggling inputs: nothing may move.
        repeat (5) step(1, 0, 0, 8'h00, 0);
        repeat (5) step(1, 1, 0, 8'h00, 0);
        step(0, 1, 0, 8'h00, 0);

        // Reset while locked, then full relock.
        do_reset();
        repeat (45) step(1, 1, 0, 8'h00, 0);
        chk("a.relock_after_reset", 64'(olock_a), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
